disc_pulse_conditioner: RTL

DISC_PULSE_CONDITIONER -- requirements
Module: disc_pulse_conditioner

---
 rtl/disc_pulse_conditioner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/disc_pulse_conditioner.sv
// Conditions an asynchronous discriminator pulse into a single-cycle hit strobe with
// minimum-width qualification, non-paralyzable dead time and saturating diagnostic counters.
module disc_pulse_conditioner #(
    parameter int MIN_WIDTH = 3,
    parameter int DEAD_TIME = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 disc_pulse,
    input  logic                 count_clear,
    output logic                 hit,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] glitch_count,
    output logic [CNT_WIDTH-1:0] pileup_count
);

    localparam int WW = $clog2(MIN_WIDTH + 1);
    localparam int DW = $clog2(DEAD_TIME + 1);
    localparam logic [WW-1:0] WIDTH_LAST = WW'(MIN_WIDTH - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TIME);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        QUALIFY  = 2'd2,
        DEAD     = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [WW-1:0]   width_cnt_reg, width_cnt_next;
    logic [DW-1:0]   dead_cnt_reg, dead_cnt_next;
    logic            s1_reg, s2_reg, s3_reg;
    logic [1:0]      fill_reg;
    logic            hit_reg, hit_next;
    logic            busy_reg;
    logic            rise;
    logic [1:0]      cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_reg [2];

    assign rise = s2_reg & ~s3_reg;

    // fill_reg marks when s2 holds a real sample rather than its reset value, so a
    // pulse held high across reset is not mistaken for a low level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            s3_reg   <= 1'b0;
            fill_reg <= 2'b00;
        end else begin
            s1_reg   <= disc_pulse;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_LOW;
            width_cnt_reg <= '0;
            dead_cnt_reg  <= '0;
            hit_reg       <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            width_cnt_reg <= width_cnt_next;
            dead_cnt_reg  <= dead_cnt_next;
            hit_reg       <= hit_next;
            busy_reg      <= (state_next != ARMED);
        end
    end

    always_comb begin
        state_next     = state_reg;
        width_cnt_next = width_cnt_reg;
        dead_cnt_next  = dead_cnt_reg;
        hit_next       = 1'b0;
        cnt_inc        = 2'b00;
        case (state_reg)
            WAIT_LOW: begin
                width_cnt_next = '0;
                dead_cnt_next  = '0;
                if (fill_reg[1] && !s2_reg)
                    state_next = ARMED;
            end
            ARMED: begin
                if (en && s2_reg) begin
                    if (MIN_WIDTH == 1) begin
                        hit_next      = 1'b1;
                        state_next    = DEAD;
                        dead_cnt_next = DW'(1);
                    end else begin
                        state_next     = QUALIFY;
                        width_cnt_next = WW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (s2_reg) begin
                    if (width_cnt_reg == WIDTH_LAST) begin
                        hit_next       = 1'b1;
                        state_next     = DEAD;
                        dead_cnt_next  = DW'(1);
                        width_cnt_next = '0;
                    end else begin
                        width_cnt_next = width_cnt_reg + WW'(1);
                    end
                end else begin
                    cnt_inc[0]     = 1'b1;
                    state_next     = ARMED;
                    width_cnt_next = '0;
                end
            end
            DEAD: begin
                // dead_cnt counts the hit cycle as 1, so leaving at DEAD_LAST spans DEAD_TIME cycles
                cnt_inc[1] = rise;
                if (dead_cnt_reg == DEAD_LAST) begin
                    state_next    = WAIT_LOW;
                    dead_cnt_next = '0;
                end else begin
                    dead_cnt_next = dead_cnt_reg + DW'(1);
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    // Index 0: glitch counter, index 1: pileup counter; both saturate, clear has priority.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || count_clear)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}}))
                    cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    endgenerate

    assign hit          = hit_reg;
    assign busy         = busy_reg;
    assign glitch_count = cnt_reg[0];
    assign pileup_count = cnt_reg[1];

endmodule
